// File: rtl/cache_replace_policy_if.sv
// Handshake bundle between the cache FSM and the victim-selection unit.
// The FSM side is the master; the replacement unit is the slave.
interface cache_replace_policy_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7
);
  localparam int LOGW = $clog2(NUMWAYS);

  logic [1:0]         Mode;
  logic               CacheEn;
  logic               FlushStage;
  logic [SETLEN-1:0]  CacheSetData;
  logic [SETLEN-1:0]  PAdr;
  logic [NUMWAYS-1:0] HitWay;
  logic [NUMWAYS-1:0] ValidWay;
  logic               LRUWriteEn;
  logic               SetValid;
  logic               InvalidateCache;
  logic [NUMWAYS-1:0] VictimWay;
  logic [LOGW-1:0]    VictimWayEnc;

  modport master (
    output Mode, CacheEn, FlushStage,
    output CacheSetData, PAdr,
    output HitWay, ValidWay,
    output LRUWriteEn, SetValid,
    output InvalidateCache,
    input  VictimWay, VictimWayEnc
  );

  modport slave (
    input  Mode, CacheEn, FlushStage,
    input  CacheSetData, PAdr,
    input  HitWay, ValidWay,
    input  LRUWriteEn, SetValid,
    input  InvalidateCache,
    output VictimWay, VictimWayEnc
  );
endinterface

// File: rtl/cache_replace_policy.sv
// Run-time selectable victim picker: tree PLRU, LFSR random, round-robin.
// Per-set state lives in a flop array with registered read and bypass.
module cache_replace_policy #(
  parameter int          NUMWAYS  = 4,
  parameter int          NUMLINES = 128,
  parameter int          SETLEN   = 7,
  parameter int          LFSRLEN  = 16,
  parameter logic [31:0] LFSRSEED = 32'hACE1
) (
  input logic clk,
  input logic reset,
  cache_replace_policy_if.slave bus
);
  localparam int LOGW = $clog2(NUMWAYS);
  localparam int PW   = NUMWAYS - 1;
  localparam logic [LFSRLEN-1:0] SEED =
    LFSRSEED[LFSRLEN-1:0];

  typedef struct packed {
    logic [PW-1:0]   plru;
    logic [LOGW-1:0] rr;
  } state_t;

  state_t mem [NUMLINES];
  state_t curr;
  state_t nxt;

  logic [LFSRLEN-1:0] lfsr;
  logic               fb;
  logic               inv_found;
  logic [LOGW-1:0]    inv_enc;
  logic [LOGW-1:0]    plru_enc;
  logic [LOGW-1:0]    hit_enc;
  logic [LOGW-1:0]    acc_enc;
  logic [LOGW-1:0]    victim_enc;
  logic               wr;
  logic               bypass;

  generate
    if (LFSRLEN == 8) begin : g_l8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (LFSRLEN == 32) begin : g_l32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_l16
      assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
    end
  endgenerate

  always_comb begin
    int k;
    logic b;
    inv_found = 1'b0;
    inv_enc   = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!bus.ValidWay[i]) begin
        inv_found = 1'b1;
        inv_enc   = LOGW'(i);
      end
    end
    // Tree walk: node bit 0 steers toward the lower half.
    plru_enc = '0;
    k = 0;
    for (int l = 0; l < LOGW; l++) begin
      b = curr.plru[PW-1-k];
      plru_enc[LOGW-1-l] = b;
      k = 2 * k + 1 + int'(b);
    end
  end

  always_comb begin
    victim_enc = plru_enc;
    unique case (1'b1)
      inv_found:
        victim_enc = inv_enc;
      !inv_found && bus.Mode == 2'b01:
        victim_enc = lfsr[LOGW-1:0];
      !inv_found && bus.Mode == 2'b10:
        victim_enc = curr.rr;
      default:
        victim_enc = plru_enc;
    endcase
  end

  always_comb begin
    hit_enc = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (bus.HitWay[i]) hit_enc = hit_enc | LOGW'(i);
    end
  end

  assign acc_enc = bus.SetValid ? victim_enc : hit_enc;

  // Every node on the path is pointed away from the accessed way.
  always_comb begin
    int k;
    logic b;
    nxt = curr;
    k = 0;
    for (int l = 0; l < LOGW; l++) begin
      b = acc_enc[LOGW-1-l];
      nxt.plru[PW-1-k] = ~b;
      k = 2 * k + 1 + int'(b);
    end
    if (bus.SetValid) nxt.rr = curr.rr + 1'b1;
  end

  assign wr = bus.LRUWriteEn & ~bus.FlushStage
            & ~bus.InvalidateCache;
  assign bypass = wr && (bus.PAdr == bus.CacheSetData);

  always_ff @(posedge clk) begin
    if (reset || bus.InvalidateCache) begin
      for (int i = 0; i < NUMLINES; i++) mem[i] <= '0;
      curr <= '0;
      lfsr <= SEED;
    end else begin
      if (wr) mem[bus.PAdr] <= nxt;
      if (bus.CacheEn)
        curr <= bypass ? nxt : mem[bus.CacheSetData];
      if (wr && bus.SetValid)
        lfsr <= {lfsr[LFSRLEN-2:0], fb};
    end
  end

  assign bus.VictimWayEnc = victim_enc;
  assign bus.VictimWay    = NUMWAYS'(1) << victim_enc;
endmodule

// File: tb/tb_cache_replace_policy.sv
// Scoreboard bench for cache_replace_policy, 4 ways, 16-bit LFSR.
// Expected victims are queued with the stimulus and checked after it.
module tb_cache_replace_policy;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_replace_policy_if #(.NUMWAYS(4), .SETLEN(7)) bus ();

  cache_replace_policy dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string tag;
    int    enc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m;
  logic [15:0] tmp;

  function automatic logic [15:0] lfsr_adv(logic [15:0] x);
    return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(string tag, int enc);
    exp_t e;
    e.tag = tag;
    e.enc = enc;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    logic [3:0] w;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got no entry expected one");
    end else begin
      e = sb.pop_front();
      w = 4'b0001 << e.enc;
      check({e.tag, "_way"}, 32'(bus.VictimWay), 32'(w));
      check({e.tag, "_enc"}, 32'(bus.VictimWayEnc),
            32'(e.enc));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read(logic [6:0] set);
    bus.CacheSetData = set;
    cyc();
  endtask

  task automatic access(logic [6:0] set, logic [3:0] hit,
                        logic fill, logic flush);
    bus.PAdr         = set;
    bus.CacheSetData = set;
    bus.HitWay       = hit;
    bus.SetValid     = fill;
    bus.FlushStage   = flush;
    bus.LRUWriteEn   = 1'b1;
    @(posedge clk);
    if (fill && !flush) lfsr_m = lfsr_adv(lfsr_m);
    #1;
    bus.LRUWriteEn = 1'b0;
    bus.SetValid   = 1'b0;
    bus.FlushStage = 1'b0;
    bus.HitWay     = '0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.Mode            = 2'b01;
    bus.CacheEn         = 1'b1;
    bus.FlushStage      = 1'b0;
    bus.CacheSetData    = '0;
    bus.PAdr            = '0;
    bus.HitWay          = '0;
    bus.ValidWay        = 4'hF;
    bus.LRUWriteEn      = 1'b0;
    bus.SetValid        = 1'b0;
    bus.InvalidateCache = 1'b0;
    lfsr_m              = 16'hACE1;
    cyc();
    cyc();
    reset = 1'b0;

    push("rst_rand", 1); #1; pop_chk();
    bus.Mode = 2'b00;
    push("rst_plru", 0); #1; pop_chk();
    bus.Mode = 2'b10;
    push("rst_rr", 0); #1; pop_chk();

    bus.Mode = 2'b01;
    push("rand_fill", 3);
    access(7'd0, 4'b0000, 1'b1, 1'b0);
    pop_chk();

    bus.Mode = 2'b00;
    push("plru_rd5", 0);  read(7'd5); pop_chk();
    push("plru_hit0", 2);
    access(7'd5, 4'b0001, 1'b0, 1'b0); pop_chk();
    push("plru_hit2", 1);
    access(7'd5, 4'b0100, 1'b0, 1'b0); pop_chk();
    push("plru_rd6", 0);  read(7'd6); pop_chk();
    push("plru_rd5b", 1); read(7'd5); pop_chk();

    bus.CacheEn = 1'b0;
    push("hold", 1); read(7'd6); pop_chk();
    bus.CacheEn = 1'b1;

    bus.Mode = 2'b10;
    push("rr_rd3", 0); read(7'd3); pop_chk();
    push("rr_f1", 1);
    access(7'd3, 4'b0000, 1'b1, 1'b0); pop_chk();
    push("rr_hit", 1);
    access(7'd3, 4'b0010, 1'b0, 1'b0); pop_chk();
    push("rr_f2", 2);
    access(7'd3, 4'b0000, 1'b1, 1'b0); pop_chk();
    push("rr_f3", 3);
    access(7'd3, 4'b0000, 1'b1, 1'b0); pop_chk();
    push("rr_f0", 0);
    access(7'd3, 4'b0000, 1'b1, 1'b0); pop_chk();

    bus.ValidWay = 4'b1011;
    for (int m = 0; m < 3; m++) begin
      bus.Mode = 2'(m);
      push("inv1011", 2); #1; pop_chk();
    end
    bus.ValidWay = 4'b0000;
    push("inv0000", 0); #1; pop_chk();
    bus.ValidWay = 4'hF;

    bus.Mode = 2'b01;
    push("rand_now", int'(lfsr_m[1:0])); #1; pop_chk();
    push("flush_rand", int'(lfsr_m[1:0]));
    access(7'd0, 4'b0000, 1'b1, 1'b1); pop_chk();
    bus.Mode = 2'b00;
    push("flush_plru", 1);
    access(7'd5, 4'b0010, 1'b0, 1'b1); pop_chk();
    read(7'd6);
    push("flush_rd5", 1); read(7'd5); pop_chk();

    bus.Mode = 2'b01;
    tmp = lfsr_adv(lfsr_m);
    push("rand_fill2", int'(tmp[1:0]));
    access(7'd0, 4'b0000, 1'b1, 1'b0); pop_chk();

    bus.InvalidateCache = 1'b1;
    bus.PAdr            = 7'd5;
    bus.CacheSetData    = 7'd5;
    bus.HitWay          = 4'b0001;
    bus.SetValid        = 1'b1;
    bus.LRUWriteEn      = 1'b1;
    cyc();
    bus.InvalidateCache = 1'b0;
    bus.LRUWriteEn      = 1'b0;
    bus.SetValid        = 1'b0;
    bus.HitWay          = '0;
    lfsr_m              = 16'hACE1;

    push("inval_rand", 1); #1; pop_chk();
    bus.Mode = 2'b00;
    push("inval_plru", 0); #1; pop_chk();
    push("inval_rd5", 0); read(7'd5); pop_chk();
    push("inval_rd0", 0); read(7'd0); pop_chk();
    bus.Mode = 2'b10;
    push("inval_rr3", 0); read(7'd3); pop_chk();

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_left: got %0d entries expected 0",
               sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
